mc_river_engine: RTL

Parametrised, move-driven river-crossing engine for the missionary-cannibal puzzle. Where the previous block replayed one fixed 12-state solution for N=3, this engine accepts arbitrary boat moves over a valid/ready handshake. It checks each move for legality against configurable headcount and boat capacity, updates the bank state, and flags rejections and the solved condition. It sits between the move source (FSM sequencer, host, or button front-end) and the display/LED logic that consumes the bank outputs.

---
 rtl/mc_river_engine_if.sv | 36 +++
 rtl/mc_river_engine.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mc_river_engine_if.sv
// Move handshake and bank-state bundle for mc_river_engine.
// CW must equal the engine's headcount width, $clog2(N+1).
// Optional MC_MOVE_COUNT_EN adds the move_count field.
interface mc_river_engine_if #(
  parameter int unsigned CW = 2
);
  logic          move_valid;
  logic          move_ready;
  logic [CW-1:0] move_m;
  logic [CW-1:0] move_c;
  logic [CW-1:0] missionary_next;
  logic [CW-1:0] cannibal_next;
  logic          boat_side;
  logic [2:0]    finish;
`ifdef MC_MOVE_COUNT_EN
  logic [15:0]   move_count;

  modport master (
    output move_valid, move_m, move_c,
    input  move_ready, missionary_next, cannibal_next, boat_side, finish, move_count
  );
  modport slave (
    input  move_valid, move_m, move_c,
    output move_ready, missionary_next, cannibal_next, boat_side, finish, move_count
  );
`else
  modport master (
    output move_valid, move_m, move_c,
    input  move_ready, missionary_next, cannibal_next, boat_side, finish
  );
  modport slave (
    input  move_valid, move_m, move_c,
    output move_ready, missionary_next, cannibal_next, boat_side, finish
  );
`endif
endinterface

// File: rtl/mc_river_engine.sv
// Move-driven missionary/cannibal river-crossing engine.
// Accepts one boat move per handshake, checks legality in a single EVAL cycle,
// then updates the left-bank headcounts and boat side or pulses a reject.
// Optional MC_MOVE_COUNT_EN adds a saturating 16-bit count of legal moves.
module mc_river_engine #(
  parameter int unsigned N   = 3,
  parameter int unsigned CAP = 2,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               restart_i,
  mc_river_engine_if.slave   bus_io
);

  typedef enum logic [1:0] {StPlay, StEval, StSolved} state_e;

  localparam logic [CW-1:0] NumW = CW'(N);
  localparam logic [CW:0]   CapW = (CW + 1)'(CAP);

  state_e        state_q, state_d;
  logic [CW-1:0] ml_q, ml_d, cl_q, cl_d;
  logic          boat_q, boat_d;
  logic [CW-1:0] mm_q, mm_d, mc_q, mc_d;
  logic          reject_q, reject_d;
`ifdef MC_MOVE_COUNT_EN
  logic [15:0]   count_q, count_d;
`endif

  logic [CW:0]   sum;
  logic [CW-1:0] src_m, src_c, new_ml, new_cl, new_rm, new_rc;
  logic          legal, solved;

  // Legality of the captured move against the current banks.
  always_comb begin
    sum    = {1'b0, mm_q} + {1'b0, mc_q};
    src_m  = boat_q ? (NumW - ml_q) : ml_q;
    src_c  = boat_q ? (NumW - cl_q) : cl_q;
    // Only meaningful when the source bank holds enough people.
    new_ml = boat_q ? (ml_q + mm_q) : (ml_q - mm_q);
    new_cl = boat_q ? (cl_q + mc_q) : (cl_q - mc_q);
    new_rm = NumW - new_ml;
    new_rc = NumW - new_cl;
    legal  = (sum != '0) && (sum <= CapW) &&
             (src_m >= mm_q) && (src_c >= mc_q) &&
             ((new_ml == '0) || (new_ml >= new_cl)) &&
             ((new_rm == '0) || (new_rm >= new_rc));
    solved = legal && (new_ml == '0) && (new_cl == '0) && !boat_q;
  end

  // Next-state: capture in PLAY, resolve in EVAL, park in SOLVED.
  always_comb begin
    state_d  = state_q;
    ml_d     = ml_q;
    cl_d     = cl_q;
    boat_d   = boat_q;
    mm_d     = mm_q;
    mc_d     = mc_q;
    reject_d = 1'b0;
`ifdef MC_MOVE_COUNT_EN
    count_d  = count_q;
`endif
    unique case (state_q)
      StPlay: begin
        if (bus_io.move_valid) begin
          mm_d    = bus_io.move_m;
          mc_d    = bus_io.move_c;
          state_d = StEval;
        end
      end
      StEval: begin
        state_d = StPlay;
        if (legal) begin
          ml_d   = new_ml;
          cl_d   = new_cl;
          boat_d = ~boat_q;
`ifdef MC_MOVE_COUNT_EN
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
          if (solved) state_d = StSolved;
        end else begin
          reject_d = 1'b1;
        end
      end
      StSolved: begin
      end
      default: state_d = StPlay;
    endcase
  end

  // State register; reset and restart re-initialise identically.
  always_ff @(posedge clock_i) begin
    if (reset_i || restart_i) begin
      state_q  <= StPlay;
      ml_q     <= NumW;
      cl_q     <= NumW;
      boat_q   <= 1'b0;
      mm_q     <= '0;
      mc_q     <= '0;
      reject_q <= 1'b0;
`ifdef MC_MOVE_COUNT_EN
      count_q  <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      ml_q     <= ml_d;
      cl_q     <= cl_d;
      boat_q   <= boat_d;
      mm_q     <= mm_d;
      mc_q     <= mc_d;
      reject_q <= reject_d;
`ifdef MC_MOVE_COUNT_EN
      count_q  <= count_d;
`endif
    end
  end

  assign bus_io.move_ready      = (state_q == StPlay);
  assign bus_io.missionary_next = ml_q;
  assign bus_io.cannibal_next   = cl_q;
  assign bus_io.boat_side       = boat_q;
  assign bus_io.finish          = {state_q == StEval, reject_q, state_q == StSolved};
`ifdef MC_MOVE_COUNT_EN
  assign bus_io.move_count      = count_q;
`endif

endmodule
